// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier and its downstream accumulate stage.
package booth_pkg;
   localparam int PROD_W        = 8;
   localparam int DEF_ACC_W     = 16;
   localparam int DEF_FRAME_LEN = 4;

   typedef enum logic {
      ACCUM = 1'b0,
      DRAIN = 1'b1
   } state_t;
endpackage

// File: rtl/booth_sat_add.sv
// Saturating add of a sign-extended product into a signed accumulator (combinational).
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] prod,
   output logic [ACC_W-1:0]  sum,
   output logic              ovf
);
   logic [ACC_W:0] wide;
   logic [ACC_W:0] prod_ext;

   assign prod_ext = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod};
   assign wide     = {acc[ACC_W-1], acc} + prod_ext;

   // Overflow whenever the guard bit disagrees with the result's sign bit.
   assign ovf = wide[ACC_W] ^ wide[ACC_W-1];

   always_comb begin
      sum = wide[ACC_W-1:0];
      if (ovf) begin
         sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
endmodule

// File: rtl/booth_prod_accum.sv
// Sums FRAME_LEN Booth products with saturation, then drains the sum LSB-first byte-wise.
//   state | meaning
//   ACCUM | accepting products into acc, counting toward FRAME_LEN
//   DRAIN | presenting acc bytes on byte_o, product input stalled
module booth_prod_accum
   import booth_pkg::*;
#(
   parameter int FRAME_LEN = DEF_FRAME_LEN,
   parameter int ACC_W     = DEF_ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_i,
   input  logic [PROD_W-1:0] prod_i,
   input  logic              prod_valid_i,
   output logic              prod_ready_o,
   output logic [7:0]        byte_o,
   output logic              byte_valid_o,
   input  logic              byte_ready_i,
   output logic              sat_o,
   output logic              busy_o
);
   localparam int NBYTES = ACC_W / 8;
   localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_t            state, state_nxt;
   logic [ACC_W-1:0]  acc, acc_nxt, acc_shr, sum;
   logic [7:0]        cnt, cnt_nxt;
   logic [IDX_W-1:0]  idx, idx_nxt, idx_inc;
   logic              sat_r, sat_nxt, ovf;
   logic [7:0]        byte_r, byte_nxt;

   booth_sat_add #(.ACC_W(ACC_W)) u_sat_add (
      .acc  (acc),
      .prod (prod_i),
      .sum  (sum),
      .ovf  (ovf)
   );

   // Next byte is pre-selected so byte_o is a clean register output.
   assign idx_inc = idx + 1'b1;
   assign acc_shr = acc >> {idx_inc, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ACCUM;
         acc    <= '0;
         cnt    <= '0;
         idx    <= '0;
         sat_r  <= 1'b0;
         byte_r <= '0;
      end else begin
         state  <= state_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
         idx    <= idx_nxt;
         sat_r  <= sat_nxt;
         byte_r <= byte_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      sat_nxt   = sat_r;
      byte_nxt  = byte_r;
      if (clear_i) begin
         state_nxt = ACCUM;
         acc_nxt   = '0;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         sat_nxt   = 1'b0;
         byte_nxt  = '0;
      end else begin
         case (state)
            ACCUM: begin
               if (prod_valid_i) begin
                  acc_nxt = sum;
                  sat_nxt = sat_r | ovf;
                  if (cnt == 8'(FRAME_LEN - 1)) begin
                     cnt_nxt   = '0;
                     idx_nxt   = '0;
                     byte_nxt  = sum[7:0];
                     state_nxt = DRAIN;
                  end else begin
                     cnt_nxt = cnt + 8'd1;
                  end
               end
            end
            DRAIN: begin
               if (byte_ready_i) begin
                  if (idx == IDX_W'(NBYTES - 1)) begin
                     acc_nxt   = '0;
                     sat_nxt   = 1'b0;
                     idx_nxt   = '0;
                     byte_nxt  = '0;
                     state_nxt = ACCUM;
                  end else begin
                     idx_nxt  = idx_inc;
                     byte_nxt = acc_shr[7:0];
                  end
               end
            end
            default: state_nxt = ACCUM;
         endcase
      end
   end

   assign prod_ready_o = (state == ACCUM);
   assign byte_valid_o = (state == DRAIN);
   assign byte_o       = byte_r;
   assign sat_o        = sat_r;
   assign busy_o       = (state == DRAIN) | (cnt != 8'd0);
endmodule

// File: tb/tb_booth_prod_accum.sv
// Directed bench for booth_prod_accum: default instance plus an ACC_W=8 instance.
module tb_booth_prod_accum;
   logic       clk = 1'b0;
   logic       rst_n;

   logic       clear, pv, pr, bv, br, sat, busy;
   logic [7:0] pd, bo;

   logic       clear8, pv8, pr8, bv8, br8, sat8, busy8;
   logic [7:0] pd8, bo8;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   booth_prod_accum u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear),
      .prod_i       (pd),
      .prod_valid_i (pv),
      .prod_ready_o (pr),
      .byte_o       (bo),
      .byte_valid_o (bv),
      .byte_ready_i (br),
      .sat_o        (sat),
      .busy_o       (busy)
   );

   booth_prod_accum #(.FRAME_LEN(4), .ACC_W(8)) u_dut8 (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear8),
      .prod_i       (pd8),
      .prod_valid_i (pv8),
      .prod_ready_o (pr8),
      .byte_o       (bo8),
      .byte_valid_o (bv8),
      .byte_ready_i (br8),
      .sat_o        (sat8),
      .busy_o       (busy8)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] p);
      int n = 0;
      @(negedge clk);
      pv = 1'b1;
      pd = p;
      while (!pr && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_timeout", 32'(pr), 32'd1);
      @(negedge clk);
      pv = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [7:0] exp);
      int n = 0;
      while (!bv && n < 100) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_valid"}, 32'(bv), 32'd1);
      check(tag, 32'(bo), 32'(exp));
      br = 1'b1;
      @(negedge clk);
      br = 1'b0;
   endtask

   initial begin
      logic [7:0] v8 [4];
      logic       s8 [4];
      v8 = '{8'd100, 8'd100, 8'(-10), 8'd5};
      s8 = '{1'b0, 1'b1, 1'b1, 1'b1};

      rst_n = 1'b0;
      clear = 1'b0; pv = 1'b0; pd = '0; br = 1'b0;
      clear8 = 1'b0; pv8 = 1'b0; pd8 = '0; br8 = 1'b0;
      #12;
      check("rst_prod_ready", 32'(pr), 32'd1);
      check("rst_byte_valid", 32'(bv), 32'd0);
      check("rst_byte",       32'(bo), 32'd0);
      check("rst_sat",        32'(sat), 32'd0);
      check("rst_busy",       32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Frame 1: 10+20-5+3 = 28, ready held high
      br = 1'b1;
      send(8'd10);
      check("f1_busy_mid", 32'(busy), 32'd1);
      send(8'd20);
      send(8'(-5));
      send(8'd3);
      check("f1_b0_valid", 32'(bv), 32'd1);
      check("f1_b0",       32'(bo), 32'h1C);
      check("f1_ready_lo0", 32'(pr), 32'd0);
      check("f1_sat",      32'(sat), 32'd0);
      @(negedge clk);
      check("f1_b1_valid", 32'(bv), 32'd1);
      check("f1_b1",       32'(bo), 32'h00);
      check("f1_ready_lo1", 32'(pr), 32'd0);
      check("f1_busy_b1",  32'(busy), 32'd1);
      @(negedge clk);
      check("f1_done_valid", 32'(bv), 32'd0);
      check("f1_ready_back", 32'(pr), 32'd1);
      check("f1_busy_done",  32'(busy), 32'd0);
      br = 1'b0;

      // Frame 2: 4 * -56 = -224 = 0xFF20
      repeat (4) send(8'(-56));
      check("f2_sat", 32'(sat), 32'd0);
      recv("f2_b0", 8'h20);
      recv("f2_b1", 8'hFF);

      // ACC_W=8: 100,100 clamps to 127, then 117, 122
      @(negedge clk);
      check("a8_ready", 32'(pr8), 32'd1);
      pv8 = 1'b1;
      pd8 = v8[0];
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("a8_sat_%0d", i), 32'(sat8), 32'(s8[i]));
         if (i < 3) pd8 = v8[i+1];
         else       pv8 = 1'b0;
      end
      check("a8_valid", 32'(bv8), 32'd1);
      check("a8_byte",  32'(bo8), 32'h7A);
      br8 = 1'b1;
      @(negedge clk);
      br8 = 1'b0;
      check("a8_done_valid", 32'(bv8), 32'd0);
      check("a8_done_sat",   32'(sat8), 32'd0);
      check("a8_done_ready", 32'(pr8), 32'd1);

      // Backpressure with a product offered during drain
      send(8'd10); send(8'd20); send(8'(-5)); send(8'd3);
      pv = 1'b1;
      pd = 8'd50;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("bp_byte_%0d", i),  32'(bo), 32'h1C);
         check($sformatf("bp_valid_%0d", i), 32'(bv), 32'd1);
         check($sformatf("bp_ready_%0d", i), 32'(pr), 32'd0);
         @(negedge clk);
      end
      pv = 1'b0;
      recv("bp_b0", 8'h1C);
      recv("bp_b1", 8'h00);
      send(8'd1); send(8'd1); send(8'd1); send(8'd1);
      recv("bp_next_b0", 8'h04);
      recv("bp_next_b1", 8'h00);

      // Clear after two products, coincident with a third
      send(8'd5); send(8'd6);
      @(negedge clk);
      pv = 1'b1; pd = 8'd100; clear = 1'b1;
      @(negedge clk);
      pv = 1'b0; clear = 1'b0;
      check("clr_busy", 32'(busy), 32'd0);
      check("clr_ready", 32'(pr), 32'd1);
      send(8'd1); send(8'd2); send(8'd3); send(8'd4);
      recv("clr_b0", 8'h0A);
      recv("clr_b1", 8'h00);

      // Reset pulse mid-drain
      send(8'd10); send(8'd20); send(8'(-5)); send(8'd3);
      recv("rd_b0", 8'h1C);
      check("rd_pre_valid", 32'(bv), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rd_valid", 32'(bv), 32'd0);
      check("rd_byte",  32'(bo), 32'd0);
      check("rd_ready", 32'(pr), 32'd1);
      check("rd_busy",  32'(busy), 32'd0);
      check("rd_sat",   32'(sat), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) send(8'd7);
      recv("rd_next_b0", 8'h1C);
      recv("rd_next_b1", 8'h00);
      @(negedge clk);
      check("end_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Downstream stage of the 4-bit Booth multiplier.
- Consumes the 8-bit two's-complement products and accumulates FRAME_LEN of them into a saturating signed accumulator.
- Streams the frame sum out byte-wise, LSB first, over a valid/ready handshake to the chip output pins.
- Exerts backpressure on the product source while draining.

Parameters:
- FRAME_LEN, 4, number of products summed per frame; legal range 1..255.
- ACC_W, 16, accumulator width in bits; multiple of 8, range 8..32; drained as ACC_W/8 bytes.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- clear_i  input  1  synchronous frame abort/clear
- prod_i  input  8  signed product from Booth multiplier
- prod_valid_i  input  1  prod_i valid this cycle
- prod_ready_o  output  1  block can accept a product
- byte_o  output  8  result byte
- byte_valid_o  output  1  byte_o valid
- byte_ready_i  input  1  downstream accepts byte_o
- sat_o  output  1  current frame sum saturated (sticky within frame)
- busy_o  output  1  frame in progress or draining

Behaviour:
- Reset (rst_n low, async), all registers cleared:
  - acc=0, cnt=0, idx=0, state=ACCUM.
  - Outputs: byte_valid_o=0, byte_o=0, sat_o=0, busy_o=0, prod_ready_o=1.
  - Reset mid-drain abandons the frame with no further bytes.
- States: ACCUM, DRAIN.
  - prod_ready_o = (state==ACCUM), combinational from state.
  - byte_valid_o = (state==DRAIN), registered state.
- ACCUM, on prod_valid_i & prod_ready_o at posedge:
  - acc <= satadd(acc, sign_extend(prod_i)); cnt <= cnt+1.
  - If cnt==FRAME_LEN-1: cnt <= 0, state <= DRAIN, idx <= 0.
  - byte_valid_o rises on the same edge as the last accept (1-cycle latency from last product to first byte).
- Saturation:
  - Compute in ACC_W+1 bits.
  - Clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
  - sat_o set on the same edge; held through DRAIN.
- DRAIN:
  - byte_o = acc[8*idx +: 8]; registered, stable while byte_valid_o & !byte_ready_i.
  - Each handshake (byte_valid_o & byte_ready_i): idx++.
  - On the handshake with idx==ACC_W/8-1: acc<=0, sat_o<=0, state<=ACCUM. prod_ready_o rises the next cycle.
  - Products offered during DRAIN are not accepted; the source must hold them.
- clear_i has priority over every other event in the same cycle:
  - acc=0, cnt=0, idx=0, sat_o=0, state=ACCUM.
  - Products presented in the same cycle are discarded.
- busy_o = (state==DRAIN) | (cnt!=0).
- FRAME_LEN=1: every accepted product produces a drain.
- No pipelining of the next frame during drain.

Decomposition:
- Shared package booth_pkg:
  - PROD_W=8.
  - State typedef {ACCUM, DRAIN}.
  - Default ACC_W and FRAME_LEN constants; shared with the multiplier wrapper.
- One sub-module: booth_sat_add (signed ACC_W + sign-extended PROD_W; outputs clamped sum and overflow flag), combinational.
- Rest in one module.

Test Plan:
- Defaults, products 10, 20, -5, 3, byte_ready_i=1:
  - bytes 0x1C then 0x00, sat_o=0.
  - prod_ready_o low exactly 2 cycles, busy_o falls after 2nd byte.
- Defaults, four products of -56:
  - sum -224, bytes 0x20 then 0xFF.
- ACC_W=8, FRAME_LEN=4, products 100, 100, -10, 5:
  - acc clamps to 127 after product 2, ends at 122; sat_o=1 from 2nd accept until drain done.
  - single byte 0x7A.
- Backpressure: hold byte_ready_i=0 for 3 cycles in DRAIN while prod_valid_i=1:
  - byte_o stable at 0x1C, prod_ready_o=0, no accumulation.
  - sequence resumes correctly when ready returns.
- clear_i asserted after 2 of 4 products, together with a 3rd prod_valid_i:
  - next 4 products 1, 2, 3, 4 yield 0x0A, 0x00.
  - cleared-cycle product ignored.
- rst_n pulsed low after first byte handshake in DRAIN:
  - byte_valid_o=0 immediately, all outputs at reset values.
  - next frame of 7, 7, 7, 7 yields 0x1C, 0x00.
